tcm_port_arb: RTL and testbench

TCM_PORT_ARB -- requirements
Module: tcm_port_arb

---
 rtl/tcm_port_arb.sv | 130 +++++++++++++
 tb/tb_tcm_port_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tcm_port_arb.sv
// Arbiter sharing one 64-bit TCM RAM port between the CPU data port and an external (AXI) port.
// Define TCM_ARB_FAIR_EN to replace fixed external priority with starvation-bounded alternation.
module tcm_port_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic [10:0] mem_d_req_tag_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic [31:0] mem_d_data_rd_o,
    input  logic        ext_rd_i,
    input  logic [3:0]  ext_wr_i,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_write_data_i,
    output logic        ext_accept_o,
    output logic        ext_ack_o,
    output logic [31:0] ext_read_data_o,
    output logic [12:0] ram_addr_o,
    output logic [63:0] ram_data_o,
    output logic [7:0]  ram_wr_o,
    input  logic [63:0] ram_data_i,
    output logic        arb_owner_o
);

    typedef enum logic {ST_CPU = 1'b0, ST_EXT = 1'b1} state_e;

    state_e      state_q;
    logic        hi_q;
    logic        cpu_ack_q;
    logic        ext_ack_q;
    logic [10:0] tag_q;

    logic        cpu_req;
    logic        ext_req;
    logic        go_ext;
    logic        go_cpu;
    logic        cpu_acc;
    logic        ext_acc;
    logic [31:0] owner_addr;
    logic [31:0] owner_wdata;
    logic [3:0]  owner_wr;

    assign cpu_req = mem_d_rd_i | (mem_d_wr_i != 4'h0);
    assign ext_req = ext_rd_i | (ext_wr_i != 4'h0);
    assign cpu_acc = cpu_req & (state_q == ST_CPU);
    assign ext_acc = ext_req & (state_q == ST_EXT);

`ifdef TCM_ARB_FAIR_EN
    localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT - 1);

    logic [3:0] ext_wait_q;
    logic [3:0] cpu_wait_q;

    assign go_ext = ext_req & (!cpu_req | (ext_wait_q == WAIT_MAX));
    assign go_cpu = !ext_req | (cpu_req & (cpu_wait_q == WAIT_MAX));

    // Each side's counter only runs while the other side owns the port; saturates at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_wait_q <= 4'h0;
            cpu_wait_q <= 4'h0;
        end else if (state_q == ST_CPU) begin
            cpu_wait_q <= 4'h0;
            if (go_ext)
                ext_wait_q <= 4'h0;
            else if (ext_req && ext_wait_q != 4'hF)
                ext_wait_q <= ext_wait_q + 4'h1;
        end else begin
            ext_wait_q <= 4'h0;
            if (go_cpu)
                cpu_wait_q <= 4'h0;
            else if (cpu_req && cpu_wait_q != 4'hF)
                cpu_wait_q <= cpu_wait_q + 4'h1;
        end
    end
`else
    assign go_ext = ext_req;
    assign go_cpu = !ext_req;
`endif

    assign owner_addr  = (state_q == ST_EXT) ? ext_addr_i       : mem_d_addr_i;
    assign owner_wdata = (state_q == ST_EXT) ? ext_write_data_i : mem_d_data_wr_i;
    assign owner_wr    = (state_q == ST_EXT) ? ext_wr_i         : mem_d_wr_i;

    // Strobes are zero whenever the owner is not writing, so non-owner writes never land.
    assign ram_addr_o = owner_addr[15:3];
    assign ram_data_o = owner_addr[2] ? {owner_wdata, 32'h0} : {32'h0, owner_wdata};
    assign ram_wr_o   = owner_addr[2] ? {owner_wr, 4'h0}     : {4'h0, owner_wr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CPU;
            hi_q      <= 1'b0;
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            tag_q     <= 11'h0;
        end else begin
            hi_q      <= owner_addr[2];
            cpu_ack_q <= cpu_acc;
            ext_ack_q <= ext_acc;
            if (cpu_acc)
                tag_q <= mem_d_req_tag_i;
            case (state_q)
                ST_CPU:  if (go_ext) state_q <= ST_EXT;
                ST_EXT:  if (go_cpu) state_q <= ST_CPU;
                default: state_q <= ST_CPU;
            endcase
        end
    end

    assign mem_d_accept_o   = (state_q == ST_CPU);
    assign ext_accept_o     = (state_q == ST_EXT);
    assign arb_owner_o      = state_q;
    assign mem_d_ack_o      = cpu_ack_q;
    assign ext_ack_o        = ext_ack_q;
    assign mem_d_resp_tag_o = tag_q;
    assign mem_d_data_rd_o  = hi_q ? ram_data_i[63:32] : ram_data_i[31:0];
    assign ext_read_data_o  = hi_q ? ram_data_i[63:32] : ram_data_i[31:0];

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_d_addr_i[31:16], mem_d_addr_i[1:0],
                                ext_addr_i[31:16], ext_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed bench for tcm_port_arb: reset, CPU read/write, ext write, contention and mid-burst reset.
module tb_tcm_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic [10:0] mem_d_resp_tag_o;
    logic [31:0] mem_d_data_rd_o;
    logic        ext_rd_i;
    logic [3:0]  ext_wr_i;
    logic [31:0] ext_addr_i;
    logic [31:0] ext_write_data_i;
    logic        ext_accept_o;
    logic        ext_ack_o;
    logic [31:0] ext_read_data_o;
    logic [12:0] ram_addr_o;
    logic [63:0] ram_data_o;
    logic [7:0]  ram_wr_o;
    logic [63:0] ram_data_i;
    logic        arb_owner_o;

    int n_cmp = 0;
    int n_bad = 0;

    tcm_port_arb #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_addr_i(mem_d_addr_i),
        .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_resp_tag_o(mem_d_resp_tag_o), .mem_d_data_rd_o(mem_d_data_rd_o),
        .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
        .ext_write_data_i(ext_write_data_i), .ext_accept_o(ext_accept_o),
        .ext_ack_o(ext_ack_o), .ext_read_data_o(ext_read_data_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_data_i), .arb_owner_o(arb_owner_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_cpu_accept"}, 64'(mem_d_accept_o), 64'h1);
        check_eq({pfx, "_ext_accept"}, 64'(ext_accept_o), 64'h0);
        check_eq({pfx, "_cpu_ack"}, 64'(mem_d_ack_o), 64'h0);
        check_eq({pfx, "_ext_ack"}, 64'(ext_ack_o), 64'h0);
        check_eq({pfx, "_tag"}, 64'(mem_d_resp_tag_o), 64'h0);
        check_eq({pfx, "_owner"}, 64'(arb_owner_o), 64'h0);
        check_eq({pfx, "_rdata_lo"}, 64'(mem_d_data_rd_o), 64'h55667788);
    endtask

    logic exp_own;
    logic prev_own;

    initial begin
        rst_n = 1'b0;
        mem_d_rd_i = 1'b0; mem_d_wr_i = 4'h0; mem_d_addr_i = 32'h0;
        mem_d_data_wr_i = 32'h0; mem_d_req_tag_i = 11'h0;
        ext_rd_i = 1'b0; ext_wr_i = 4'h0; ext_addr_i = 32'h0; ext_write_data_i = 32'h0;
        ram_data_i = 64'h11223344_55667788;
        #3;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // CPU read of the upper word
        mem_d_addr_i = 32'h4; mem_d_rd_i = 1'b1; mem_d_req_tag_i = 11'h5A5;
        #1;
        check_eq("rd_ram_addr", 64'(ram_addr_o), 64'h0);
        check_eq("rd_no_wr", 64'(ram_wr_o), 64'h0);
        tick();
        mem_d_rd_i = 1'b0; mem_d_addr_i = 32'h0; mem_d_req_tag_i = 11'h0;
        check_eq("rd_ack", 64'(mem_d_ack_o), 64'h1);
        check_eq("rd_tag", 64'(mem_d_resp_tag_o), 64'h5A5);
        check_eq("rd_data_hi", 64'(mem_d_data_rd_o), 64'h11223344);
        tick();
        check_eq("rd_ack_drop", 64'(mem_d_ack_o), 64'h0);
        check_eq("rd_tag_hold", 64'(mem_d_resp_tag_o), 64'h5A5);
        check_eq("rd_data_lo", 64'(mem_d_data_rd_o), 64'h55667788);
        check_eq("ext_rdata_lo", 64'(ext_read_data_o), 64'h55667788);

        // CPU writes, lower then upper half
        mem_d_addr_i = 32'h10; mem_d_wr_i = 4'hF; mem_d_data_wr_i = 32'hDEADBEEF;
        #1;
        check_eq("wr_ram_addr", 64'(ram_addr_o), 64'h2);
        check_eq("wr_strb_lo", 64'(ram_wr_o), 64'h0F);
        check_eq("wr_data_lo", ram_data_o, 64'h00000000_DEADBEEF);
        tick();
        mem_d_addr_i = 32'h14; mem_d_wr_i = 4'h3;
        #1;
        check_eq("wr_strb_hi", 64'(ram_wr_o), 64'h30);
        check_eq("wr_data_hi", ram_data_o, 64'hDEADBEEF_00000000);
        tick();
        mem_d_wr_i = 4'h0; mem_d_addr_i = 32'h0; mem_d_data_wr_i = 32'h0;
        tick();

        // External write while CPU idle
        ext_addr_i = 32'h8; ext_wr_i = 4'hF; ext_write_data_i = 32'hCAFEF00D;
        #1;
        check_eq("ext_nonowner_strb", 64'(ram_wr_o), 64'h0);
        check_eq("ext_accept_pre", 64'(ext_accept_o), 64'h0);
        tick();
        check_eq("ext_owner", 64'(arb_owner_o), 64'h1);
        check_eq("ext_cpu_accept", 64'(mem_d_accept_o), 64'h0);
        check_eq("ext_accept", 64'(ext_accept_o), 64'h1);
        check_eq("ext_ram_addr", 64'(ram_addr_o), 64'h1);
        check_eq("ext_strb", 64'(ram_wr_o), 64'h0F);
        check_eq("ext_wdata", ram_data_o, 64'h00000000_CAFEF00D);
        check_eq("ext_ack_early", 64'(ext_ack_o), 64'h0);
        tick();
        ext_wr_i = 4'h0; ext_addr_i = 32'h0; ext_write_data_i = 32'h0;
        check_eq("ext_ack", 64'(ext_ack_o), 64'h1);
        check_eq("ext_owner_hold", 64'(arb_owner_o), 64'h1);
        tick();
        check_eq("ext_ack_drop", 64'(ext_ack_o), 64'h0);
        check_eq("ext_release", 64'(arb_owner_o), 64'h0);

        // Both sides requesting continuously
        mem_d_rd_i = 1'b1; mem_d_req_tag_i = 11'h123; ext_rd_i = 1'b1;
        prev_own = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef TCM_ARB_FAIR_EN
            exp_own = 1'((k >> 2) & 1);
`else
            exp_own = 1'b1;
`endif
            check_eq($sformatf("cont_owner_%0d", k), 64'(arb_owner_o), 64'(exp_own));
            check_eq($sformatf("cont_cpu_ack_%0d", k), 64'(mem_d_ack_o), 64'(!prev_own));
            check_eq($sformatf("cont_ext_ack_%0d", k), 64'(ext_ack_o), 64'(prev_own));
            prev_own = exp_own;
        end
        check_eq("cont_tag", 64'(mem_d_resp_tag_o), 64'h123);
        mem_d_rd_i = 1'b0; ext_rd_i = 1'b0;
        repeat (2) tick();
        check_eq("cont_idle_owner", 64'(arb_owner_o), 64'h0);

        // Reset asserted in the middle of an external read burst
        ext_rd_i = 1'b1; ext_addr_i = 32'h4;
        tick();
        tick();
        check_eq("burst_ack", 64'(ext_ack_o), 64'h1);
        check_eq("burst_data_hi", 64'(ext_read_data_o), 64'h11223344);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        ext_rd_i = 1'b0; ext_addr_i = 32'h0;
        #2 rst_n = 1'b1;
        tick();
        check_eq("post_rst_ext_ack", 64'(ext_ack_o), 64'h0);
        check_eq("post_rst_cpu_ack", 64'(mem_d_ack_o), 64'h0);
        check_eq("post_rst_owner", 64'(arb_owner_o), 64'h0);
        check_eq("post_rst_accept", 64'(mem_d_accept_o), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
